// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the EX-stage issue logic and the shift sequencer.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, shamt, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, a, shamt, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer replacing the barrel shifter in EX.
// Define SHIFT_BY4_EN to step 4 bits per cycle while at least 4 remain.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic             clk,
  input logic             reset_n,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] result_r, result_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [SHW-1:0]   step_n;
  logic [1:0]       op_r, op_nxt;
  logic [WIDTH-1:0] acc_step;
  logic             by4;

`ifdef SHIFT_BY4_EN
  assign by4 = (cnt >= SHW'(4));
`else
  assign by4 = 1'b0;
`endif

  assign step_n = by4 ? SHW'(4) : SHW'(1);

  // Only fixed 1- and 4-bit shifts exist, so no variable-amount shifter is built.
  always_comb begin
    acc_step = acc;
    case (op_r)
      OP_SLL: acc_step = by4 ? {acc[WIDTH-5:0], 4'b0000}    : {acc[WIDTH-2:0], 1'b0};
      OP_SRL: acc_step = by4 ? {4'b0000, acc[WIDTH-1:4]}    : {1'b0, acc[WIDTH-1:1]};
      OP_SRA: acc_step = by4 ? {{4{acc[WIDTH-1]}}, acc[WIDTH-1:4]}
                             : {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_step = acc;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    op_nxt     = op_r;
    result_nxt = result_r;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          acc_nxt = bus.a;
          cnt_nxt = bus.shamt;
          op_nxt  = bus.op;
          if ((bus.shamt == '0) || (bus.op == OP_RSV)) begin
            state_nxt  = DONE;
            result_nxt = bus.a;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_nxt = acc_step;
        cnt_nxt = cnt - step_n;
        if (cnt == step_n) begin
          state_nxt  = DONE;
          result_nxt = acc_step;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Flush beats everything, including a completion landing in the same cycle.
    if (bus.flush) begin
      state_nxt  = IDLE;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      op_nxt     = op_r;
      result_nxt = result_r;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      op_r     <= OP_SLL;
      result_r <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      op_r     <= op_nxt;
      result_r <= result_nxt;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.stall  = (state == SHIFT) || ((state == IDLE) && bus.start && !bus.flush);
  assign bus.done   = (state == DONE) && !bus.flush;
  assign bus.result = result_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized and directed checks of shift_seq_ctrl against a plain-arithmetic shift model.
module tb_shift_seq_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   passes;
  logic [31:0] prev_result;

  shift_seq_ctrl_if #(.WIDTH(32), .SHW(5)) bus ();

  shift_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [4:0] sh);
    case (op)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [4:0] sh);
    if (op == 2'b11 || sh == 0) return 1;
`ifdef SHIFT_BY4_EN
    return int'(sh) / 4 + int'(sh) % 4 + 1;
`else
    return int'(sh) + 1;
`endif
  endfunction

  // Called at a falling edge; presents one request and returns at the falling edge where done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                        output logic [31:0] res, output int lat, output bit seen);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.shamt = sh;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      seen = bus.done;
    end
    res = bus.result;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.shamt = '0;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", bus.done); else passes++;
    checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL reset_stall got=%b exp=0", bus.stall); else passes++;
    checks++; if (bus.result !== 32'h0) $display("[TB] FAIL reset_result got=%h exp=0", bus.result); else passes++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    prev_result = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  ops [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] as  [4] = '{32'h0000_0001, 32'h8000_0000, 32'hF000_000F, 32'h1234_5678};
    logic [4:0]  shs [4] = '{5'd4, 5'd31, 5'd0, 5'd17};
    logic [31:0] exps[4] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'hF000_000F, 32'h1234_5678};
    logic [31:0] res;
    int lat;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], shs[i], res, lat, seen);
      checks++; if (!seen) $display("[TB] FAIL dir%0d_done got=timeout exp=pulse", i); else passes++;
      checks++;
      if (lat != model_latency(ops[i], shs[i]))
        $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, lat, model_latency(ops[i], shs[i]));
      else passes++;
      checks++; if (res !== exps[i]) $display("[TB] FAIL dir%0d_result got=%h exp=%h", i, res, exps[i]); else passes++;
      prev_result = exps[i];
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] res;
    int lat;
    bit seen;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      sh = 5'($urandom_range(0, 31));
      if (i % 5 == 0) a[31] = 1'b1;
      run_op(op, a, sh, res, lat, seen);
      checks++;
      if (!seen || lat != model_latency(op, sh))
        $display("[TB] FAIL rnd%0d_latency got=%0d seen=%b exp=%0d", i, lat, seen, model_latency(op, sh));
      else passes++;
      checks++;
      if (res !== model_result(op, a, sh))
        $display("[TB] FAIL rnd%0d_result op=%b a=%h sh=%0d got=%h exp=%h", i, op, a, sh, res, model_result(op, a, sh));
      else passes++;
      prev_result = model_result(op, a, sh);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("[TB] FAIL rnd%0d_pulse got=done%b busy%b exp=done0 busy0", i, bus.done, bus.busy);
      else passes++;
      checks++; if (bus.result !== prev_result) $display("[TB] FAIL rnd%0d_hold got=%h exp=%h", i, bus.result, prev_result); else passes++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    logic [31:0] res;
    bit saw_done;
    int lat;
    bit seen;
    a = $urandom;
    saw_done = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = a;
    bus.shamt = 5'd10;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) saw_done = 1'b1;
    end
    checks++; if (bus.stall !== 1'b1) $display("[TB] FAIL flush_stall_shift got=%b exp=1", bus.stall); else passes++;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done) saw_done = 1'b1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL flush_busy got=%b exp=0", bus.busy); else passes++;
    checks++; if (saw_done) $display("[TB] FAIL flush_no_done got=1 exp=0"); else passes++;
    checks++; if (bus.result !== prev_result) $display("[TB] FAIL flush_result got=%h exp=%h", bus.result, prev_result); else passes++;
    a = $urandom;
    run_op(2'b00, a, 5'd3, res, lat, seen);
    checks++;
    if (!seen || lat != model_latency(2'b00, 5'd3) || res !== (a << 3))
      $display("[TB] FAIL flush_restart got=%h lat=%0d exp=%h lat=%0d", res, lat, a << 3, model_latency(2'b00, 5'd3));
    else passes++;
    prev_result = a << 3;
    @(negedge clk);
    // Simultaneous start and flush in IDLE must drop the request.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.shamt = 5'd2;
    #1;
    checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL flush_start_stall got=%b exp=0", bus.stall); else passes++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL flush_start_busy got=%b exp=0", bus.busy); else passes++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'hDEAD_BEEF;
    bus.shamt = 5'd20;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'h0)
      $display("[TB] FAIL midreset_outputs got=busy%b done%b stall%b res=%h exp=all0",
               bus.busy, bus.done, bus.stall, bus.result);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    prev_result = '0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midreset_idle got=%b exp=0", bus.busy); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1;
    logic [31:0] a2;
    int cyc;
    int first_done;
    int second_done;
    a1 = $urandom;
    a2 = $urandom | 32'h8000_0000;
    first_done  = -1;
    second_done = -1;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = a1;
    bus.shamt = 5'd3;
    cyc = 0;
    while (second_done < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.op    = 2'b10;
        bus.a     = a2;
        bus.shamt = 5'd7;
      end
      if (first_done >= 0 && cyc == first_done + 2) bus.start = 1'b0;
      if (bus.done && first_done < 0) begin
        first_done = cyc;
        checks++; if (bus.result !== (a1 << 3)) $display("[TB] FAIL b2b_first_result got=%h exp=%h", bus.result, a1 << 3); else passes++;
        checks++;
        if (bus.busy !== 1'b1 || bus.stall !== 1'b0)
          $display("[TB] FAIL b2b_done_flags got=busy%b stall%b exp=busy1 stall0", bus.busy, bus.stall);
        else passes++;
      end else if (bus.done) begin
        second_done = cyc;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (first_done != model_latency(2'b00, 5'd3))
      $display("[TB] FAIL b2b_first_latency got=%0d exp=%0d", first_done, model_latency(2'b00, 5'd3));
    else passes++;
    checks++;
    if (second_done != model_latency(2'b00, 5'd3) + 1 + model_latency(2'b10, 5'd7))
      $display("[TB] FAIL b2b_second_latency got=%0d exp=%0d", second_done,
               model_latency(2'b00, 5'd3) + 1 + model_latency(2'b10, 5'd7));
    else passes++;
    checks++;
    if (bus.result !== model_result(2'b10, a2, 5'd7))
      $display("[TB] FAIL b2b_second_result got=%h exp=%h", bus.result, model_result(2'b10, a2, 5'd7));
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
